cpu_storebuffer_circ: RTL and testbench

Parametrised circular-FIFO store buffer between the CPU store path and a direct-mapped data cache. Successor to the shifting store buffer:
- head/tail pointers, so no entry shifting;
- data word generalised to BYTES_IN_DATA bytes;
- valid/ready handshakes on push and drain;
- youngest-wins per-byte load forwarding;
- optional write coalescing into the tail entry.

---
 rtl/cpu_storebuffer_pkg.sv | 51 +++++
 rtl/cpu_storebuffer_fwd.sv | 37 +++
 rtl/cpu_storebuffer_circ.sv | 156 +++++++++++++++
 tb/tb_cpu_storebuffer_circ.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_storebuffer_pkg.sv
// cpu_storebuffer_pkg: shared entry type, sizing and mask helper
// for the circular store buffer. Sizes default from core-wide macros.
`ifndef STOREBUFFER_SIZE
`define STOREBUFFER_SIZE 4
`endif
`ifndef PHYSICAL_ADDR_WIDTH
`define PHYSICAL_ADDR_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif
`ifndef NUM_CACHE_LINES
`define NUM_CACHE_LINES 4
`endif
`ifndef LINE_WIDTH
`define LINE_WIDTH 128
`endif

package cpu_storebuffer_pkg;

  localparam int SB_SIZE       = `STOREBUFFER_SIZE;
  localparam int SB_TAG_W      = `PHYSICAL_ADDR_WIDTH;
  localparam int SB_BYTES      = `WORD_WIDTH / `BYTE_WIDTH;
  localparam int SB_LINES      = `NUM_CACHE_LINES;
  localparam int SB_LINE_BYTES = `LINE_WIDTH / `BYTE_WIDTH;

  localparam int PTR_W   = $clog2(SB_SIZE);
  localparam int CNT_W   = PTR_W + 1;
  localparam int OFF_W   = $clog2(SB_BYTES);
  localparam int PSIZE_W = $clog2(OFF_W + 1);

  typedef struct packed {
    logic [SB_TAG_W-1:0]   addr;
    logic [SB_BYTES-1:0]   byte_en;
    logic [SB_BYTES*8-1:0] data;
  } sb_entry_t;

  // low (1<<size) bytes set, unshifted
  function automatic logic [SB_BYTES-1:0] size_to_mask(
    input logic [PSIZE_W-1:0] size
  );
    logic [SB_BYTES-1:0] m;
    for (int i = 0; i < SB_BYTES; i++)
      m[i] = (i < (1 << size));
    return m;
  endfunction

endpackage

// File: rtl/cpu_storebuffer_fwd.sv
// cpu_storebuffer_fwd: youngest-wins per-byte forwarding select
// over all buffer entries, walked in age order from head.
module cpu_storebuffer_fwd
  import cpu_storebuffer_pkg::*;
(
  input  sb_entry_t             ent [SB_SIZE],
  input  logic [SB_SIZE-1:0]    valid,
  input  logic [PTR_W-1:0]      head,
  input  logic [SB_TAG_W-1:0]   lookup_addr,
  output logic [SB_BYTES-1:0]   hit_bytes,
  output logic [SB_BYTES*8-1:0] data
);

  logic [SB_TAG_W-1:0] word;
  logic [PTR_W-1:0]    idx;
  logic                unused_off;

  assign word       = {lookup_addr[SB_TAG_W-1:OFF_W], OFF_W'(0)};
  assign unused_off = ^lookup_addr[OFF_W-1:0];

  // oldest first so younger matches overwrite older bytes
  always_comb begin
    hit_bytes = '0;
    data      = '0;
    idx       = head;
    for (int k = 0; k < SB_SIZE; k++) begin
      idx = head + PTR_W'(k);
      if (valid[idx] && ent[idx].addr == word) begin
        hit_bytes = hit_bytes | ent[idx].byte_en;
        for (int b = 0; b < SB_BYTES; b++)
          if (ent[idx].byte_en[b])
            data[b*8 +: 8] = ent[idx].data[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/cpu_storebuffer_circ.sv
// cpu_storebuffer_circ: circular store buffer with forwarding.
// Optional tail coalescing: define CPU_STOREBUFFER_COALESCE_EN.
module cpu_storebuffer_circ
  import cpu_storebuffer_pkg::*;
#(
  parameter int SIZE          = SB_SIZE,
  parameter int TAG_WIDTH     = SB_TAG_W,
  parameter int BYTES_IN_DATA = SB_BYTES,
  parameter int NUM_LINES     = SB_LINES,
  parameter int BYTES_IN_LINE = SB_LINE_BYTES
)(
  input  logic clock,
  input  logic reset,
  input  logic push_valid,
  output logic push_ready,
  input  logic [TAG_WIDTH-1:0] push_addr,
  input  logic [$clog2($clog2(BYTES_IN_DATA)+1)-1:0] push_size,
  input  logic [BYTES_IN_DATA*8-1:0] push_data,
  input  logic [TAG_WIDTH-1:0] lookup_addr,
  output logic [BYTES_IN_DATA-1:0] fwd_hit_bytes,
  output logic [BYTES_IN_DATA*8-1:0] fwd_data,
  output logic drain_valid,
  input  logic drain_ready,
  output logic [TAG_WIDTH-1:0] drain_addr,
  output logic [BYTES_IN_DATA-1:0] drain_byte_en,
  output logic [BYTES_IN_DATA*8-1:0] drain_data,
  output logic empty,
  output logic full,
  output logic [$clog2(SIZE):0] count,
  output logic [NUM_LINES-1:0] hit_lines
);

  localparam int PW   = $clog2(SIZE);
  localparam int CW   = PW + 1;
  localparam int OW   = $clog2(BYTES_IN_DATA);
  localparam int BN   = BYTES_IN_DATA;
  localparam int LOFF = $clog2(BYTES_IN_LINE);
  localparam int LW   = $clog2(NUM_LINES);

  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  sb_entry_t           ent [SIZE];
  logic [SIZE-1:0]     valid;
  logic                fire_push;
  logic                fire_drain;
  logic                merge;
  logic                alloc;
  logic [OW-1:0]       off;
  logic [2*BN-1:0]     wide_mask;
  logic [BN-1:0]       new_mask;
  logic [BN*8-1:0]     new_data;
  logic [TAG_WIDTH-1:0] new_addr;
  logic [CW-1:0]       count_next;

  assign push_ready = ~full;
  assign drain_valid = ~empty;
  assign fire_push  = push_valid & push_ready;
  assign fire_drain = drain_valid & drain_ready;

  assign off       = push_addr[OW-1:0];
  assign new_addr  = {push_addr[TAG_WIDTH-1:OW], OW'(0)};
  assign wide_mask = {BN'(0), size_to_mask(push_size)} << off;
  assign new_mask  = wide_mask[BN-1:0];
  assign new_data  = push_data << {off, 3'b000};

`ifdef CPU_STOREBUFFER_COALESCE_EN
  logic [PW-1:0] tail_m1;
  assign tail_m1 = tail - PW'(1);
  assign merge = fire_push
    && (count >= CW'(2) || (count == CW'(1) && !fire_drain))
    && tail_m1 != head
    && ent[tail_m1].addr == new_addr;
`else
  assign merge = 1'b0;
`endif

  assign alloc      = fire_push & ~merge;
  assign count_next = count + CW'(alloc) - CW'(fire_drain);

  assign drain_addr    = ent[head].addr;
  assign drain_byte_en = ent[head].byte_en;
  assign drain_data    = ent[head].data;

  // entry i is live if its distance from head is below count
  always_comb begin
    valid = '0;
    for (int i = 0; i < SIZE; i++)
      valid[i] = {1'b0, PW'(i) - head} < count;
  end

  // one-hot OR of the cache line each live entry maps to
  always_comb begin
    hit_lines = '0;
    for (int i = 0; i < SIZE; i++)
      if (valid[i])
        hit_lines[ent[i].addr[LOFF +: LW]] = 1'b1;
  end

  // pointers, occupancy and registered full/empty flags
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (alloc) tail <= tail + PW'(1);
      if (fire_drain) head <= head + PW'(1);
      count <= count_next;
      empty <= count_next == '0;
      full  <= count_next == CW'(SIZE);
    end
  end

  // entry storage; contents are don't-care until allocated
  always_ff @(posedge clock) begin
    if (alloc) begin
      ent[tail].addr    <= new_addr;
      ent[tail].byte_en <= new_mask;
      ent[tail].data    <= new_data;
    end
`ifdef CPU_STOREBUFFER_COALESCE_EN
    if (merge) begin
      ent[tail_m1].byte_en <= ent[tail_m1].byte_en | new_mask;
      for (int b = 0; b < BN; b++)
        if (new_mask[b])
          ent[tail_m1].data[b*8 +: 8] <= new_data[b*8 +: 8];
    end
`endif
  end

`ifndef SYNTHESIS
  // flag stores crossing the word and handshake violations
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (fire_push && |wide_mask[2*BN-1:BN])
        $error("store buffer: push crosses word boundary");
      if (fire_push && count == CW'(SIZE))
        $error("store buffer: push while full");
      if (fire_drain && count == '0)
        $error("store buffer: drain while empty");
    end
  end
`endif

  cpu_storebuffer_fwd u_fwd (
    .ent         (ent),
    .valid       (valid),
    .head        (head),
    .lookup_addr (lookup_addr),
    .hit_bytes   (fwd_hit_bytes),
    .data        (fwd_data)
  );

endmodule

// File: tb/tb_cpu_storebuffer_circ.sv
// tb_cpu_storebuffer_circ: directed bench for the circular store
// buffer, default sizing SIZE=4, 4-byte words, 4 lines of 16 bytes.
module tb_cpu_storebuffer_circ;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        push_valid = 1'b0;
  logic        drain_ready = 1'b0;
  logic [31:0] push_addr = '0;
  logic [31:0] push_data = '0;
  logic [31:0] lookup_addr = '0;
  logic [1:0]  push_size = '0;
  logic        push_ready;
  logic        drain_valid;
  logic        empty;
  logic        full;
  logic [3:0]  fwd_hit_bytes;
  logic [3:0]  drain_byte_en;
  logic [3:0]  hit_lines;
  logic [31:0] fwd_data;
  logic [31:0] drain_addr;
  logic [31:0] drain_data;
  logic [2:0]  count;

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  cpu_storebuffer_circ dut (
    .clock         (clock),
    .reset         (reset),
    .push_valid    (push_valid),
    .push_ready    (push_ready),
    .push_addr     (push_addr),
    .push_size     (push_size),
    .push_data     (push_data),
    .lookup_addr   (lookup_addr),
    .fwd_hit_bytes (fwd_hit_bytes),
    .fwd_data      (fwd_data),
    .drain_valid   (drain_valid),
    .drain_ready   (drain_ready),
    .drain_addr    (drain_addr),
    .drain_byte_en (drain_byte_en),
    .drain_data    (drain_data),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .hit_lines     (hit_lines)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [1:0] s,
                      input logic [31:0] d);
    @(negedge clock);
    push_valid = 1'b1;
    push_addr  = a;
    push_size  = s;
    push_data  = d;
    @(negedge clock);
    push_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    @(negedge clock);
    drain_ready = 1'b1;
    repeat (n) @(negedge clock);
    drain_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_a;
    int exp_c;

    // reset state
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_push_ready", push_ready, 1);
    chk("rst_drain_valid", drain_valid, 0);
    chk("rst_hit_lines", hit_lines, 0);
    chk("rst_fwd_hit", fwd_hit_bytes, 0);

    // single word store
    push(32'h1004, 2'd2, 32'hDEADBEEF);
    chk("w_count", count, 1);
    chk("w_drain_valid", drain_valid, 1);
    chk("w_drain_addr", drain_addr, 32'h1004);
    chk("w_drain_be", drain_byte_en, 4'b1111);
    chk("w_drain_data", drain_data, 32'hDEADBEEF);
    drain(1);
    chk("w_empty", empty, 1);

    // byte then half into the same word
    push(32'h2001, 2'd0, 32'h000000AA);
    push(32'h2002, 2'd1, 32'h0000BBCC);
    lookup_addr = 32'h2000;
    #1;
    chk("bh_hit", fwd_hit_bytes, 4'b1110);
    chk("bh_data", fwd_data, 32'hBBCCAA00);
    chk("bh_count", count, 2);
    lookup_addr = 32'h2003;
    #1;
    chk("bh_hit_off", fwd_hit_bytes, 4'b1110);
    lookup_addr = 32'h2004;
    #1;
    chk("bh_miss", fwd_hit_bytes, 4'b0000);
    chk("bh_miss_data", fwd_data, 32'h0);
    drain(2);

    // youngest wins; head is never merged into
    push(32'h3000, 2'd2, 32'h11111111);
    push(32'h3000, 2'd0, 32'h00000022);
    lookup_addr = 32'h3000;
    #1;
    chk("yw_data", fwd_data, 32'h11111122);
    chk("yw_hit", fwd_hit_bytes, 4'b1111);
    chk("yw_head_data", drain_data, 32'h11111111);
    chk("yw_count", count, 2);
    drain(2);
    chk("yw_empty", empty, 1);

    // fill across pointer wrap
    for (int i = 1; i <= 4; i++)
      push(32'h100 * i, 2'd2, 32'h100 * i);
    chk("fill_full", full, 1);
    chk("fill_push_ready", push_ready, 0);
    chk("fill_count", count, 4);
    @(negedge clock);
    push_valid = 1'b1;
    push_addr  = 32'h500;
    push_data  = 32'h500;
    push_size  = 2'd2;
    repeat (2) @(negedge clock);
    chk("hold_count", count, 4);
    chk("hold_head", drain_addr, 32'h100);

    // concurrent push/drain streaming
    for (int i = 0; i <= 8; i++) begin
      exp_c = (i == 0) ? 4 : (i <= 5) ? 3 : 8 - i;
      chk("stream_count", count, exp_c);
      if (i <= 7) begin
        exp_a = 32'h100 * (i + 1);
        chk("stream_addr", drain_addr, exp_a);
        chk("stream_data", drain_data, exp_a);
      end else begin
        chk("stream_empty", empty, 1);
      end
      push_valid  = (i <= 4);
      push_addr   = (i == 0) ? 32'h500 : 32'h100 * (i + 4);
      push_data   = push_addr;
      drain_ready = (i <= 7);
      @(negedge clock);
    end
    push_valid  = 1'b0;
    drain_ready = 1'b0;

    // cache line occupancy
    push(32'h40, 2'd2, 32'hA5A5A5A5);
    push(32'h80, 2'd2, 32'h5A5A5A5A);
    chk("hl_line0", hit_lines, 4'b0001);
    push(32'h1F0, 2'd2, 32'h01020304);
    chk("hl_line3", hit_lines, 4'b1001);
    chk("hl_count", count, 3);
    lookup_addr = 32'h40;
    #1;
    chk("hl_fwd", fwd_data, 32'hA5A5A5A5);

    // mid-operation reset discards entries
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mr_empty", empty, 1);
    chk("mr_count", count, 0);
    chk("mr_drain_valid", drain_valid, 0);
    chk("mr_fwd_hit", fwd_hit_bytes, 0);
    chk("mr_hit_lines", hit_lines, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
